// File: rtl/register_controller.sv
// Command sequencer for a single register: turns one accepted command into a
// burst of one-hot register strobes, then reports completion with done/err/result.
module register_controller #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_op,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   input  logic [CNT_WIDTH-1:0]  cmd_count,
   input  logic                  abort,
   input  logic [DATA_WIDTH-1:0] reg_out,
   output logic                  reg_cl,
   output logic                  reg_ld,
   output logic                  reg_inc,
   output logic                  reg_dec,
   output logic                  reg_sr,
   output logic                  reg_sl,
   output logic                  reg_ir,
   output logic                  reg_il,
   output logic [DATA_WIDTH-1:0] reg_in,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [DATA_WIDTH-1:0] result
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   localparam logic [2:0] OP_CLEAR = 3'd0;
   localparam logic [2:0] OP_LOAD  = 3'd1;
   localparam logic [2:0] OP_ADDN  = 3'd2;
   localparam logic [2:0] OP_SUBN  = 3'd3;
   localparam logic [2:0] OP_SHR   = 3'd4;
   localparam logic [2:0] OP_SHL   = 3'd5;
   localparam logic [2:0] OP_ASR   = 3'd6;
   localparam logic [2:0] OP_ROR   = 3'd7;

   state_t                state, state_d;
   logic [2:0]            op_q, op_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CNT_WIDTH-1:0]  rem_q, rem_d;
   logic                  err_q, err_d;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         op_q   <= '0;
         data_q <= '0;
         rem_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_d;
         op_q   <= op_d;
         data_q <= data_d;
         rem_q  <= rem_d;
         err_q  <= err_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statements can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state;
      op_d      = op_q;
      data_d    = data_q;
      rem_d     = rem_q;
      err_d     = err_q;
      cmd_ready = 1'b0;
      reg_cl    = 1'b0;
      reg_ld    = 1'b0;
      reg_inc   = 1'b0;
      reg_dec   = 1'b0;
      reg_sr    = 1'b0;
      reg_sl    = 1'b0;
      reg_ir    = 1'b0;
      reg_il    = 1'b0;
      reg_in    = '0;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      result    = '0;

      // Outputs are gated in the reset cycle itself, before the state register clears.
      if (!rst) begin
         result = reg_out;
         unique case (state)
            IDLE: begin
               cmd_ready = 1'b1;
               err_d     = 1'b0;
               if (cmd_valid) begin
                  op_d    = cmd_op;
                  data_d  = cmd_data;
                  rem_d   = cmd_count;
                  state_d = EXEC;
               end
            end

            EXEC: begin
               busy = 1'b1;
               if (abort) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else if (op_q == OP_CLEAR || op_q == OP_LOAD) begin
                  reg_cl  = (op_q == OP_CLEAR);
                  reg_ld  = (op_q == OP_LOAD);
                  reg_in  = (op_q == OP_LOAD) ? data_q : '0;
                  state_d = DONE;
               end else if (rem_q != '0) begin
                  unique case (op_q)
                     OP_ADDN: reg_inc = 1'b1;
                     OP_SUBN: reg_dec = 1'b1;
                     OP_SHR:  reg_sr  = 1'b1;
                     OP_SHL:  reg_sl  = 1'b1;
                     OP_ASR: begin
                        reg_sr = 1'b1;
                        reg_ir = reg_out[DATA_WIDTH-1];
                     end
                     OP_ROR: begin
                        reg_sr = 1'b1;
                        reg_ir = reg_out[0];
                     end
                     default: ;
                  endcase
                  rem_d = rem_q - CNT_WIDTH'(1);
                  if (rem_q == CNT_WIDTH'(1)) state_d = DONE;
               end else begin
                  // Zero-count iterative op: one empty EXEC cycle.
                  state_d = DONE;
               end
            end

            DONE: begin
               busy    = 1'b1;
               done    = 1'b1;
               err     = err_q;
               err_d   = 1'b0;
               state_d = IDLE;
            end

            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_register_controller.sv
// Directed bench for register_controller; includes a behavioural register that
// reacts to the strobes so reg_out feedback is realistic.
module tb_register_controller;

   localparam int DW = 16;
   localparam int CW = 4;

   localparam logic [2:0] OP_CLEAR = 3'd0;
   localparam logic [2:0] OP_LOAD  = 3'd1;
   localparam logic [2:0] OP_ADDN  = 3'd2;
   localparam logic [2:0] OP_SUBN  = 3'd3;
   localparam logic [2:0] OP_SHR   = 3'd4;
   localparam logic [2:0] OP_SHL   = 3'd5;
   localparam logic [2:0] OP_ASR   = 3'd6;
   localparam logic [2:0] OP_ROR   = 3'd7;

   // Strobe vector order: {cl, ld, inc, dec, sr, sl}
   localparam logic [5:0] S_NONE = 6'b000000;
   localparam logic [5:0] S_LD   = 6'b010000;
   localparam logic [5:0] S_INC  = 6'b001000;
   localparam logic [5:0] S_DEC  = 6'b000100;
   localparam logic [5:0] S_SR   = 6'b000010;
   localparam logic [5:0] S_SL   = 6'b000001;

   logic          clk, rst, reg_rst;
   logic          cmd_valid, cmd_ready, abort;
   logic [2:0]    cmd_op;
   logic [DW-1:0] cmd_data;
   logic [CW-1:0] cmd_count;
   logic [DW-1:0] reg_out, reg_in, result;
   logic          reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il;
   logic          busy, done, err;

   int checks = 0;
   int errors = 0;

   register_controller #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
      .abort(abort), .reg_out(reg_out),
      .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_dec(reg_dec),
      .reg_sr(reg_sr), .reg_sl(reg_sl), .reg_ir(reg_ir), .reg_il(reg_il),
      .reg_in(reg_in), .busy(busy), .done(done), .err(err), .result(result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Controlled register with its own reset.
   always_ff @(posedge clk) begin
      if (reg_rst)      reg_out <= '0;
      else if (reg_cl)  reg_out <= '0;
      else if (reg_ld)  reg_out <= reg_in;
      else if (reg_inc) reg_out <= reg_out + 16'd1;
      else if (reg_dec) reg_out <= reg_out - 16'd1;
      else if (reg_sr)  reg_out <= {reg_ir, reg_out[DW-1:1]};
      else if (reg_sl)  reg_out <= {reg_out[DW-2:0], reg_il};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] strobes();
      return {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offers a command for one accepting edge; returns in the first EXEC cycle.
   task automatic issue(input logic [2:0] op, input logic [DW-1:0] data, input logic [CW-1:0] cnt);
      int n = 0;
      while (!cmd_ready && n < 50) begin
         step();
         n++;
      end
      check("ready_before_issue", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_count = cnt;
      step();
      cmd_valid = 1'b0;
      #1;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 50) begin
         step();
         n++;
      end
      check("done_seen", 32'(done), 32'd1);
   endtask

   task automatic load_reg(input logic [DW-1:0] data);
      issue(OP_LOAD, data, '0);
      wait_done();
      check("load_result", 32'(result), 32'(data));
      step();
   endtask

   // Continuous rules: at most one strobe; no strobes/ir/il outside EXEC.
   always @(negedge clk) begin
      check("strobe_onehot", 32'($onehot0(strobes())), 32'd1);
      if (!(busy && !done))
         check("idle_strobes", 32'({strobes(), reg_ir, reg_il}), 32'd0);
   end

   initial begin
      logic [3:0] ror_ir;
      ror_ir    = 4'b0100;
      rst       = 1'b1;
      reg_rst   = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_data  = '0;
      cmd_count = '0;
      abort     = 1'b0;

      // Power-on reset
      step();
      check("rst_ready", 32'(cmd_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_strobes", 32'(strobes()), 32'(S_NONE));
      step();
      rst     = 1'b0;
      reg_rst = 1'b0;
      #1;
      check("post_rst_ready", 32'(cmd_ready), 32'd1);
      check("post_rst_busy", 32'(busy), 32'd0);

      // LOAD latency
      issue(OP_LOAD, 16'hA5C3, '0);
      check("load_strobe", 32'(strobes()), 32'(S_LD));
      check("load_reg_in", 32'(reg_in), 32'h0000A5C3);
      check("load_busy", 32'(busy), 32'd1);
      check("load_ready_busy", 32'(cmd_ready), 32'd0);
      step();
      check("load_done", 32'(done), 32'd1);
      check("load_res", 32'(result), 32'h0000A5C3);
      check("load_err", 32'(err), 32'd0);
      step();
      check("load_ready_after", 32'(cmd_ready), 32'd1);
      check("load_done_pulse", 32'(done), 32'd0);

      // ADDN with wrap-around
      load_reg(16'hFFFE);
      issue(OP_ADDN, '0, 4'd3);
      for (int i = 0; i < 3; i++) begin
         check("addn_inc", 32'(strobes()), 32'(S_INC));
         step();
      end
      check("addn_done", 32'(done), 32'd1);
      check("addn_res", 32'(result), 32'h00000001);
      step();

      // ROR with ir following reg_out[0]
      load_reg(16'h1234);
      issue(OP_ROR, '0, 4'd4);
      for (int i = 0; i < 4; i++) begin
         check("ror_sr", 32'(strobes()), 32'(S_SR));
         check("ror_ir", 32'(reg_ir), 32'(ror_ir[i]));
         step();
      end
      check("ror_done", 32'(done), 32'd1);
      check("ror_res", 32'(result), 32'h00004123);
      step();

      // ASR sign fill
      load_reg(16'h8004);
      issue(OP_ASR, '0, 4'd2);
      for (int i = 0; i < 2; i++) begin
         check("asr_sr", 32'(strobes()), 32'(S_SR));
         check("asr_ir", 32'(reg_ir), 32'd1);
         step();
      end
      check("asr_res", 32'(result), 32'h0000E001);
      step();

      // SHL single step
      load_reg(16'h8001);
      issue(OP_SHL, '0, 4'd1);
      check("shl_sl", 32'(strobes()), 32'(S_SL));
      check("shl_il", 32'(reg_il), 32'd0);
      step();
      check("shl_res", 32'(result), 32'h00000002);
      step();

      // Zero-count op, with cmd_valid held through busy
      load_reg(16'h00F0);
      cmd_valid = 1'b1;
      cmd_op    = OP_SHL;
      cmd_data  = '0;
      cmd_count = '0;
      step();
      cmd_op    = OP_LOAD;
      cmd_data  = 16'h5555;
      #1;
      check("zc_strobes", 32'(strobes()), 32'(S_NONE));
      check("zc_busy", 32'(busy), 32'd1);
      check("zc_ready", 32'(cmd_ready), 32'd0);
      step();
      check("zc_done", 32'(done), 32'd1);
      check("zc_res", 32'(result), 32'h000000F0);
      check("zc_ready_done", 32'(cmd_ready), 32'd0);
      step();
      check("zc_ready_idle", 32'(cmd_ready), 32'd1);
      check("zc_reg_kept", 32'(reg_out), 32'h000000F0);
      step();
      cmd_valid = 1'b0;
      #1;
      check("held_load_strobe", 32'(strobes()), 32'(S_LD));
      check("held_load_in", 32'(reg_in), 32'h00005555);
      step();
      check("held_load_res", 32'(result), 32'h00005555);
      step();

      // SUBN aborted in its third EXEC cycle
      load_reg(16'h0001);
      issue(OP_SUBN, '0, 4'd5);
      check("subn_dec1", 32'(strobes()), 32'(S_DEC));
      step();
      check("subn_dec2", 32'(strobes()), 32'(S_DEC));
      step();
      abort = 1'b1;
      #1;
      check("abort_no_strobe", 32'(strobes()), 32'(S_NONE));
      check("abort_busy", 32'(busy), 32'd1);
      step();
      abort = 1'b0;
      #1;
      check("abort_done", 32'(done), 32'd1);
      check("abort_err", 32'(err), 32'd1);
      check("abort_res", 32'(result), 32'h0000FFFF);
      step();
      check("abort_err_clear", 32'(err), 32'd0);
      check("abort_ready", 32'(cmd_ready), 32'd1);

      // Controller reset in the middle of a ROR
      load_reg(16'h0003);
      issue(OP_ROR, '0, 4'd8);
      check("mid_sr1", 32'(strobes()), 32'(S_SR));
      step();
      check("mid_sr2", 32'(strobes()), 32'(S_SR));
      step();
      rst = 1'b1;
      #1;
      check("mid_rst_strobes", 32'(strobes()), 32'(S_NONE));
      check("mid_rst_ready", 32'(cmd_ready), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      step();
      check("mid_rst2_strobes", 32'(strobes()), 32'(S_NONE));
      check("mid_rst2_ready", 32'(cmd_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("mid_rel_busy", 32'(busy), 32'd0);
      check("mid_rel_ready", 32'(cmd_ready), 32'd1);
      check("mid_reg_kept", 32'(reg_out), 32'h0000C000);
      step();
      check("mid_reg_still", 32'(reg_out), 32'h0000C000);
      load_reg(16'h0042);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
